// File: rtl/cpu_control_sequencer_if.sv
// Instruction-fetch handshake between the control sequencer (master) and instruction memory.
interface cpu_control_sequencer_if #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_valid;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Control sequencer: fetch/decode/execute/writeback stepping for the ALU datapath,
// with register-file control, PC update and flag-conditioned branches.
module cpu_control_sequencer #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned RF_ADDR_W   = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_reset,
  cpu_control_sequencer_if.master imem,
  output logic [2:0]           cpu_state,
  output logic [3:0]           alu_op,
  output logic                 alu_en_A_reg,
  output logic                 alu_en_B_reg,
  input  logic                 cc_greater,
  input  logic                 cc_equal,
  output logic [RF_ADDR_W-1:0] rf_rd_addr_a,
  output logic [RF_ADDR_W-1:0] rf_rd_addr_b,
  output logic                 rf_wr_en,
  output logic [RF_ADDR_W-1:0] rf_wr_addr,
  output logic                 rf_wr_sel,
  output logic [7:0]           imm,
  output logic                 halted
);

  localparam logic [2:0] StFetch     = 3'd0;
  localparam logic [2:0] StDecode    = 3'd1;
  localparam logic [2:0] StExecute1  = 3'd2;
  localparam logic [2:0] StExecute2  = 3'd3;
  localparam logic [2:0] StWriteback = 3'd4;
  localparam logic [2:0] StHalt      = 3'd5;

  localparam logic [3:0] OpNot  = 4'h5;
  localparam logic [3:0] OpCmp  = 4'h9;
  localparam logic [3:0] OpLdi  = 4'hA;
  localparam logic [3:0] OpBgt  = 4'hB;
  localparam logic [3:0] OpBeq  = 4'hC;
  localparam logic [3:0] OpJmp  = 4'hD;
  localparam logic [3:0] OpHalt = 4'hF;

  logic [2:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;

  logic [3:0]          opcode;
  logic                is_alu;
  logic                is_alu_wr;
  logic                in_exec;
  logic [PC_WIDTH-1:0] target;

  assign opcode    = ir_q[15:12];
  assign is_alu    = (opcode >= 4'h1) && (opcode <= OpCmp);
  assign is_alu_wr = (opcode >= 4'h1) && (opcode <= 4'h8);
  assign in_exec   = (state_q == StExecute1) || (state_q == StExecute2);
  // Branch target is absolute; only the low PC_WIDTH bits of imm8 are kept.
  assign target    = PC_WIDTH'(ir_q[7:0]);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StFetch: begin
        if (imem.imem_valid) begin
          ir_d    = imem.imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_alu)                 state_d = StExecute1;
        else if (opcode == OpHalt)  state_d = StHalt;
        else                        state_d = StWriteback;
      end
      StExecute1: state_d = StExecute2;
      StExecute2: state_d = StWriteback;
      StWriteback: begin
        state_d = StFetch;
        if ((opcode == OpJmp) || ((opcode == OpBgt) && cc_greater) ||
            ((opcode == OpBeq) && cc_equal)) begin
          pc_d = target;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    imem.imem_req  = (state_q == StFetch);
    imem.imem_addr = pc_q;
    cpu_state      = state_q;
    alu_op         = is_alu ? opcode : 4'h0;
    alu_en_A_reg   = in_exec && is_alu;
    alu_en_B_reg   = in_exec && is_alu && (opcode != OpNot);
    rf_rd_addr_a   = ir_q[9:8];
    rf_rd_addr_b   = ir_q[7:6];
    rf_wr_addr     = ir_q[11:10];
    rf_wr_en       = (state_q == StWriteback) && (is_alu_wr || (opcode == OpLdi));
    rf_wr_sel      = (opcode == OpLdi);
    imm            = ir_q[7:0];
    halted         = (state_q == StHalt);
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed self-checking bench for cpu_control_sequencer.
module tb_cpu_control_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_reset;
  logic [2:0] cpu_state;
  logic [3:0] alu_op;
  logic       alu_en_A_reg, alu_en_B_reg;
  logic       cc_greater, cc_equal;
  logic [1:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic       rf_wr_en, rf_wr_sel, halted;
  logic [7:0] imm;

  int errors = 0;
  int checks = 0;
  bit wr_seen;

  cpu_control_sequencer_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) imem_bus ();

  cpu_control_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RF_ADDR_W(2)) dut (
    .sys_clk      (sys_clk),
    .sys_reset    (sys_reset),
    .imem         (imem_bus.master),
    .cpu_state    (cpu_state),
    .alu_op       (alu_op),
    .alu_en_A_reg (alu_en_A_reg),
    .alu_en_B_reg (alu_en_B_reg),
    .cc_greater   (cc_greater),
    .cc_equal     (cc_equal),
    .rf_rd_addr_a (rf_rd_addr_a),
    .rf_rd_addr_b (rf_rd_addr_b),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_sel    (rf_wr_sel),
    .imm          (imm),
    .halted       (halted)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (rf_wr_en === 1'b1) wr_seen = 1'b1;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Presents one instruction; the DUT is expected to be in FETCH (bounded wait otherwise).
  task automatic do_fetch(input logic [15:0] instr);
    for (int i = 0; i < 8 && cpu_state != 3'd0; i++) step();
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = instr;
    step();
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 16'h0;
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    #12;
    checks++; if (cpu_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", cpu_state); end
    checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", imem_bus.imem_req); end
    checks++; if (imem_bus.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", imem_bus.imem_addr); end
    checks++; if (alu_op !== 4'h0) begin errors++; $display("FAIL reset_alu_op: got %h want 0", alu_op); end
    checks++; if ({alu_en_A_reg, alu_en_B_reg, rf_wr_en, rf_wr_sel, halted} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {alu_en_A_reg, alu_en_B_reg, rf_wr_en, rf_wr_sel, halted}); end
    checks++; if ({imm, rf_wr_addr, rf_rd_addr_a, rf_rd_addr_b} !== 14'h0) begin
      errors++; $display("FAIL reset_fields: got %h want 0", {imm, rf_wr_addr, rf_rd_addr_a, rf_rd_addr_b}); end
    @(negedge sys_clk);
    sys_reset = 1'b0;
    step();
  endtask

  task automatic test_add();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (cpu_state !== 3'd0 || imem_bus.imem_req !== 1'b1) begin
        errors++; $display("FAIL add_idle_%0d: got state %0d req %b want 0 1", i, cpu_state, imem_bus.imem_req); end
    end
    do_fetch(16'h1580);
    checks++; if (cpu_state !== 3'd1) begin errors++; $display("FAIL add_decode: got %0d want 1", cpu_state); end
    checks++; if (imem_bus.imem_addr !== 8'h01) begin errors++; $display("FAIL add_pc_inc: got %h want 01", imem_bus.imem_addr); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL add_req_low: got %b want 0", imem_bus.imem_req); end
    checks++; if (alu_en_A_reg !== 1'b0) begin errors++; $display("FAIL add_decode_en: got %b want 0", alu_en_A_reg); end
    step();
    checks++; if (cpu_state !== 3'd2) begin errors++; $display("FAIL add_ex1: got %0d want 2", cpu_state); end
    checks++; if ({alu_en_A_reg, alu_en_B_reg, alu_op} !== 6'b11_0001) begin
      errors++; $display("FAIL add_ex1_ctrl: got %b want 110001", {alu_en_A_reg, alu_en_B_reg, alu_op}); end
    checks++; if (rf_rd_addr_a !== 2'd1 || rf_rd_addr_b !== 2'd2) begin
      errors++; $display("FAIL add_rd_addr: got %0d,%0d want 1,2", rf_rd_addr_a, rf_rd_addr_b); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL add_ex1_wr: got %b want 0", rf_wr_en); end
    step();
    checks++; if (cpu_state !== 3'd3 || {alu_en_A_reg, alu_en_B_reg} !== 2'b11) begin
      errors++; $display("FAIL add_ex2: got state %0d en %b want 3 11", cpu_state, {alu_en_A_reg, alu_en_B_reg}); end
    step();
    checks++; if (cpu_state !== 3'd4) begin errors++; $display("FAIL add_wb: got %0d want 4", cpu_state); end
    checks++; if ({rf_wr_en, rf_wr_sel, rf_wr_addr} !== 4'b1001) begin
      errors++; $display("FAIL add_wb_ctrl: got %b want 1001", {rf_wr_en, rf_wr_sel, rf_wr_addr}); end
    checks++; if ({alu_en_A_reg, alu_en_B_reg} !== 2'b00) begin
      errors++; $display("FAIL add_wb_en: got %b want 00", {alu_en_A_reg, alu_en_B_reg}); end
    step();
    checks++; if (cpu_state !== 3'd0 || imem_bus.imem_addr !== 8'h01) begin
      errors++; $display("FAIL add_back_fetch: got state %0d addr %h want 0 01", cpu_state, imem_bus.imem_addr); end
  endtask

  task automatic test_not();
    do_fetch(16'h5400);
    step();
    checks++; if ({cpu_state, alu_en_A_reg, alu_en_B_reg, alu_op} !== {3'd2, 2'b10, 4'h5}) begin
      errors++; $display("FAIL not_ex1: got st %0d en %b op %h want 2 10 5", cpu_state, {alu_en_A_reg, alu_en_B_reg}, alu_op); end
    step();
    checks++; if ({cpu_state, alu_en_A_reg, alu_en_B_reg} !== {3'd3, 2'b10}) begin
      errors++; $display("FAIL not_ex2: got st %0d en %b want 3 10", cpu_state, {alu_en_A_reg, alu_en_B_reg}); end
    step();
    checks++; if ({cpu_state, rf_wr_en, rf_wr_sel, rf_wr_addr} !== {3'd4, 4'b1001}) begin
      errors++; $display("FAIL not_wb: got st %0d wr %b want 4 1001", cpu_state, {rf_wr_en, rf_wr_sel, rf_wr_addr}); end
    step();
  endtask

  task automatic test_branch();
    // pc=2: CMP, then BEQ taken with cc_equal=1
    do_fetch(16'h9000);
    step(); step(); step();
    checks++; if ({cpu_state, rf_wr_en, alu_op} !== {3'd4, 1'b0, 4'h9}) begin
      errors++; $display("FAIL cmp_wb: got st %0d wr %b op %h want 4 0 9", cpu_state, rf_wr_en, alu_op); end
    step();
    cc_equal = 1'b1;
    do_fetch(16'hC040);
    checks++; if (alu_op !== 4'h0) begin errors++; $display("FAIL beq_alu_op: got %h want 0", alu_op); end
    step();
    checks++; if (cpu_state !== 3'd4 || rf_wr_en !== 1'b0) begin
      errors++; $display("FAIL beq_wb: got st %0d wr %b want 4 0", cpu_state, rf_wr_en); end
    step();
    checks++; if (imem_bus.imem_addr !== 8'h40) begin errors++; $display("FAIL beq_taken: got %h want 40", imem_bus.imem_addr); end
    // pc=0x40: CMP, then BEQ not taken
    cc_equal = 1'b0;
    do_fetch(16'h9000);
    step(); step(); step(); step();
    do_fetch(16'hC040);
    step(); step();
    checks++; if (imem_bus.imem_addr !== 8'h42) begin errors++; $display("FAIL beq_not_taken: got %h want 42", imem_bus.imem_addr); end
    // BGT follows cc_greater, ignores cc_equal
    cc_equal = 1'b1;
    do_fetch(16'hB010);
    step(); step();
    checks++; if (imem_bus.imem_addr !== 8'h43) begin errors++; $display("FAIL bgt_not_taken: got %h want 43", imem_bus.imem_addr); end
    cc_equal = 1'b0;
    cc_greater = 1'b1;
    do_fetch(16'hB010);
    step(); step();
    cc_greater = 1'b0;
    checks++; if (imem_bus.imem_addr !== 8'h10) begin errors++; $display("FAIL bgt_taken: got %h want 10", imem_bus.imem_addr); end
  endtask

  task automatic test_wrap();
    do_fetch(16'hD0FF);
    step(); step();
    checks++; if (imem_bus.imem_addr !== 8'hFF) begin errors++; $display("FAIL jmp_ff: got %h want ff", imem_bus.imem_addr); end
    do_fetch(16'hAC5A);
    checks++; if (imem_bus.imem_addr !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %h want 00", imem_bus.imem_addr); end
    step();
    checks++; if (cpu_state !== 3'd4) begin errors++; $display("FAIL ldi_no_exec: got %0d want 4", cpu_state); end
    checks++; if ({rf_wr_en, rf_wr_sel, rf_wr_addr, imm} !== {2'b11, 2'd3, 8'h5A}) begin
      errors++; $display("FAIL ldi_wb: got %b %h want 1111 5a", {rf_wr_en, rf_wr_sel, rf_wr_addr}, imm); end
    checks++; if ({alu_op, alu_en_A_reg} !== 5'b0) begin
      errors++; $display("FAIL ldi_alu_idle: got %b want 0", {alu_op, alu_en_A_reg}); end
    step();
    checks++; if (cpu_state !== 3'd0 || imem_bus.imem_addr !== 8'h00) begin
      errors++; $display("FAIL ldi_fetch: got st %0d addr %h want 0 00", cpu_state, imem_bus.imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_fetch(16'h1580);
    step(); step();
    wr_seen = 1'b0;
    checks++; if (cpu_state !== 3'd3) begin errors++; $display("FAIL rst_mid_ex2: got %0d want 3", cpu_state); end
    sys_reset = 1'b1;
    #1;
    checks++; if (cpu_state !== 3'd0 || imem_bus.imem_addr !== 8'h00) begin
      errors++; $display("FAIL rst_mid_async: got st %0d addr %h want 0 00", cpu_state, imem_bus.imem_addr); end
    step();
    sys_reset = 1'b0;
    step(); step(); step();
    checks++; if (cpu_state !== 3'd0 || imem_bus.imem_addr !== 8'h00) begin
      errors++; $display("FAIL rst_mid_after: got st %0d addr %h want 0 00", cpu_state, imem_bus.imem_addr); end
    checks++; if (wr_seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_wr: got %b want 0", wr_seen); end
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    do_fetch(16'hF000);
    step();
    checks++; if ({cpu_state, halted, imem_bus.imem_req} !== {3'd5, 2'b10}) begin
      errors++; $display("FAIL halt_enter: got st %0d h %b req %b want 5 1 0", cpu_state, halted, imem_bus.imem_req); end
    for (int i = 0; i < 100; i++) begin
      imem_bus.imem_valid = i[0];
      imem_bus.imem_rdata = 16'h1580;
      step();
      if (halted !== 1'b1 || imem_bus.imem_req !== 1'b0 || cpu_state !== 3'd5 ||
          imem_bus.imem_addr !== 8'h01 || alu_en_A_reg !== 1'b0 || rf_wr_en !== 1'b0) bad++;
    end
    imem_bus.imem_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL halt_sticky: got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 16'h0;
    cc_greater = 1'b0;
    cc_equal   = 1'b0;
    wr_seen    = 1'b0;
    test_reset();
    test_add();
    test_not();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
